axis_bram_line_engine: RTL and testbench

Parametrised successor to the single-width AXIS/BRAM adapter datapath. It packs a 32-bit-class AXI-Stream into wide BRAM lines (write mode), or unpacks wide BRAM lines back onto an AXI-Stream (read mode).
- Adds over the previous generation: partial-line flush on s_tlast, configurable BRAM read latency, address wrap-around, and done/truncation status.
- Sits between the AXIS slave/master interface wrappers and one wide BRAM port. Configuration comes from the control register block.

---
 rtl/axis_bram_pkg.sv | 25 ++
 rtl/axis_bram_line_engine_if.sv | 28 ++
 rtl/axis_bram_line_engine_line_buf.sv | 27 ++
 rtl/axis_bram_line_engine.sv | 124 ++++++++++++
 tb/tb_axis_bram_line_engine.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_bram_pkg.sv
// axis_bram_pkg: shared helpers, state encoding and latency limits for the line engine
package axis_bram_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // lane pointer width, never narrower than one bit
  function automatic int ptr_w(input int words);
    return (clog2(words) < 1) ? 1 : clog2(words);
  endfunction
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  function automatic bit rd_lat_ok(input int lat);
    return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
  endfunction
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
endpackage

// File: rtl/axis_bram_line_engine_if.sv
// axis_bram_if: stream and wide BRAM port signals between the engine and its neighbours
interface axis_bram_if #(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_W         = 12
);
  logic [DATA_W-1:0]                s_tdata;
  logic                             s_tvalid;
  logic                             s_tlast;
  logic                             s_tready;
  logic [DATA_W-1:0]                m_tdata;
  logic                             m_tvalid;
  logic                             m_tlast;
  logic                             m_tready;
  logic                             bram_en;
  logic                             bram_we;
  logic [ADDR_W-1:0]                bram_addr;
  logic [DATA_W*WORDS_PER_LINE-1:0] bram_din;
  logic [DATA_W*WORDS_PER_LINE-1:0] bram_dout;
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
    output s_tready, m_tdata, m_tvalid, m_tlast, bram_en, bram_we, bram_addr, bram_din
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
    input  s_tready, m_tdata, m_tvalid, m_tlast, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/axis_bram_line_engine_line_buf.sv
// axis_bram_line_buf: one BRAM line of stream lanes with lane write, clear, full load and lane read
module axis_bram_line_buf #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 36,
  parameter int PTR_W  = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_clr,
  input  logic                    i_load,
  input  logic                    i_wr,
  input  logic [PTR_W-1:0]        i_ptr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [DATA_W*WORDS-1:0] i_line,
  output logic [DATA_W*WORDS-1:0] o_line,
  output logic [DATA_W-1:0]       o_lane
);
  logic [WORDS-1:0][DATA_W-1:0] r_line;
  // clear wins over a full-line load, which wins over a single lane write
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_line <= '0;
    else if (i_clr) r_line <= '0;
    else if (i_load) r_line <= i_line;
    else if (i_wr) r_line[i_ptr] <= i_data;
  assign o_line = r_line;
  assign o_lane = r_line[i_ptr];
endmodule

// File: rtl/axis_bram_line_engine.sv
// axis_bram_line_engine: packs a stream into wide BRAM lines or unpacks lines back onto a stream
module axis_bram_line_engine
  import axis_bram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_W         = 12,
  parameter int RD_LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_rw,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_bound_addr,
  axis_bram_if.slave        bus,
  output logic              busy,
  output logic              done,
  output logic              trunc
);
  localparam int PTR_W = ptr_w(WORDS_PER_LINE);
  localparam int LAT = rd_lat_ok(RD_LATENCY) ? RD_LATENCY : RD_LAT_MIN;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(WORDS_PER_LINE - 1);
  logic [2:0]                       r_state;
  logic [ADDR_W-1:0]                r_addr;
  logic [ADDR_W-1:0]                r_bound;
  logic [PTR_W-1:0]                 r_ptr;
  logic [1:0]                       r_wcnt;
  logic                             r_last;
  logic                             r_trunc;
  logic                             w_start;
  logic                             w_lane_end;
  logic                             w_at_bound;
  logic                             w_wr_end;
  logic                             w_loaded;
  logic                             w_clr;
  logic [DATA_W*WORDS_PER_LINE-1:0] w_line;
  logic [DATA_W-1:0]                w_lane;
  assign w_start    = r_state == S_IDLE && cfg_start;
  assign w_lane_end = r_ptr == LAST_LANE;
  assign w_at_bound = r_addr == r_bound;
  assign w_wr_end   = r_last || w_at_bound;
  assign w_loaded   = r_state == S_WAIT && r_wcnt == 2'(LAT - 1);
  assign w_clr      = w_start || (r_state == S_WRITE && !w_wr_end);
  axis_bram_line_buf #(.DATA_W(DATA_W), .WORDS(WORDS_PER_LINE), .PTR_W(PTR_W)) u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_load (w_loaded),
    .i_wr   (r_state == S_FILL && bus.s_tvalid),
    .i_ptr  (r_ptr),
    .i_data (bus.s_tdata),
    .i_line (bus.bram_dout),
    .o_line (w_line),
    .o_lane (w_lane)
  );
  // transfer sequencing: line fill/write loop, or fetch/wait/drain loop, over base..bound with wrap
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_bound <= '0;
      r_ptr   <= '0;
      r_wcnt  <= '0;
      r_last  <= 1'b0;
      r_trunc <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (cfg_start) begin
            r_addr  <= cfg_base_addr;
            r_bound <= cfg_bound_addr;
            r_ptr   <= '0;
            r_last  <= 1'b0;
            r_trunc <= 1'b0;
            r_state <= cfg_rw ? S_FETCH : S_FILL;
          end
        S_FILL:
          if (bus.s_tvalid) begin
            if (w_lane_end || bus.s_tlast) begin
              r_last  <= bus.s_tlast;
              r_state <= S_WRITE;
            end else r_ptr <= r_ptr + 1'b1;
          end
        S_WRITE:
          if (w_wr_end) begin
            r_trunc <= !r_last;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_ptr   <= '0;
            r_state <= S_FILL;
          end
        S_FETCH: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT:
          if (w_loaded) r_state <= S_DRAIN;
          else r_wcnt <= r_wcnt + 1'b1;
        S_DRAIN:
          if (bus.m_tready) begin
            if (!w_lane_end) r_ptr <= r_ptr + 1'b1;
            else if (w_at_bound) r_state <= S_DONE;
            else begin
              r_addr  <= r_addr + 1'b1;
              r_ptr   <= '0;
              r_state <= S_FETCH;
            end
          end
        default: r_state <= S_IDLE;
      endcase
  assign bus.s_tready  = r_state == S_FILL;
  assign bus.m_tvalid  = r_state == S_DRAIN;
  assign bus.m_tlast   = r_state == S_DRAIN && w_lane_end && w_at_bound;
  assign bus.m_tdata   = w_lane;
  assign bus.bram_en   = r_state == S_WRITE || r_state == S_FETCH;
  assign bus.bram_we   = r_state == S_WRITE;
  assign bus.bram_addr = r_addr;
  assign bus.bram_din  = w_line;
  assign busy          = r_state != S_IDLE && r_state != S_DONE;
  assign done          = r_state == S_DONE;
  assign trunc         = r_trunc;
endmodule

// File: tb/tb_axis_bram_line_engine.sv
// tb_axis_bram_line_engine: directed checks of packing, partial flush, truncation, wrap reads, backpressure and reset
module tb_axis_bram_line_engine;
  localparam int DW  = 32;
  localparam int WPL = 4;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int LW  = DW * WPL;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_rw = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW-1:0] cfg_bound_addr = '0;
  logic          busy, done, trunc;
  int            n_vec = 0;
  int            n_bad = 0;
  int            n_wr = 0;
  int            w0;
  logic [LW-1:0] mem [16];
  logic [LW-1:0] st0 = '0;
  logic [LW-1:0] st1 = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [LW-1:0] pl_data = '0;

  axis_bram_if #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) bus ();

  axis_bram_line_engine #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .ADDR_W(AW), .RD_LATENCY(LAT)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_rw         (cfg_rw),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_bound_addr (cfg_bound_addr),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .trunc          (trunc)
  );

  always #5 clk = ~clk;

  // BRAM model with a two-stage read pipeline; also serves bench preloads
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_we) begin
      mem[bus.bram_addr] <= bus.bram_din;
      n_wr <= n_wr + 1;
    end else if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.bram_en && !bus.bram_we) st0 <= mem[bus.bram_addr];
    st1 <= st0;
  end
  assign bus.bram_dout = st1;

  function automatic logic [LW-1:0] rl(input int a);
    logic [LW-1:0] v;
    for (int j = 0; j < WPL; j++) v[j*DW +: DW] = DW'((a << 8) | j);
    return v;
  endfunction

  function automatic logic [LW-1:0] ln(input int w0_, input int w1, input int w2, input int w3);
    return {DW'(w3), DW'(w2), DW'(w1), DW'(w0_)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a);
    pl_en = 1'b1;
    pl_addr = AW'(a);
    pl_data = rl(a);
    tick();
    pl_en = 1'b0;
  endtask

  task automatic start(input logic rw, input int base, input int bound);
    cfg_rw = rw;
    cfg_base_addr = AW'(base);
    cfg_bound_addr = AW'(bound);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input int n, input int first, input bit last);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bus.s_tdata = DW'(first + i);
      bus.s_tlast = last && (i == n - 1);
      bus.s_tvalid = 1'b1;
      while (!bus.s_tready && g < 20) begin
        tick();
        g++;
      end
      chk("s_handshake", bus.s_tready, 1);
      tick();
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 100) begin
      tick();
      g++;
    end
    chk(tag, done, 1);
  endtask

  task automatic read_run(input int base, input int nlines, input logic [15:0] pat, input bit poke);
    int k = 0;
    int gap = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    while (k < nlines * WPL && cyc < 400) begin
      bus.m_tready = pat[cyc % 16];
      cfg_start = poke && cyc == 6;
      cfg_rw = 1'b0;
      cfg_base_addr = AW'(9);
      cfg_bound_addr = AW'(9);
      if (stall) begin
        chk("stall_valid", bus.m_tvalid, 1);
        chk("stall_data", bus.m_tdata, pd);
        chk("stall_last", bus.m_tlast, pl);
      end
      if (bus.m_tvalid) begin
        if (!stall && k > 0) chk("bubble", gap, (k % WPL == 0) ? 1 + LAT : 0);
        gap = 0;
        if (bus.m_tready) begin
          chk("rd_word", bus.m_tdata, DW'((((base + k / WPL) % 16) << 8) | (k % WPL)));
          chk("rd_last", bus.m_tlast, k == nlines * WPL - 1);
          k++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          pd = bus.m_tdata;
          pl = bus.m_tlast;
        end
      end else begin
        chk("tlast_idle", bus.m_tlast, 0);
        gap++;
      end
      tick();
      cyc++;
    end
    cfg_start = 1'b0;
    bus.m_tready = 1'b1;
    chk("rd_count", k, nlines * WPL);
    wait_done("rd_done");
    tick();
    chk("rd_done_pulse", done, 0);
  endtask

  initial begin
    bus.s_tdata = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
    bus.m_tready = 1'b1;
    for (int a = 0; a < 16; a++) preload(a);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_tdata", bus.m_tdata, 0);
    chk("rst_bram_en", bus.bram_en, 0);
    chk("rst_bram_din", bus.bram_din, 0);
    rstn = 1'b1;
    tick();

    w0 = n_wr;
    start(1'b0, 2, 3);
    chk("t1_busy", busy, 1);
    chk("t1_s_tready", bus.s_tready, 1);
    send(8, 'h10, 1'b1);
    wait_done("t1_done");
    chk("t1_trunc", trunc, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_addr2", mem[2], ln('h10, 'h11, 'h12, 'h13));
    chk("t1_addr3", mem[3], ln('h14, 'h15, 'h16, 'h17));
    chk("t1_writes", n_wr - w0, 2);

    w0 = n_wr;
    start(1'b0, 0, 5);
    send(6, 'h10, 1'b1);
    wait_done("t2_done");
    chk("t2_trunc", trunc, 0);
    tick();
    chk("t2_addr0", mem[0], ln('h10, 'h11, 'h12, 'h13));
    chk("t2_addr1", mem[1], ln('h14, 'h15, 0, 0));
    chk("t2_addr2_kept", mem[2], ln('h10, 'h11, 'h12, 'h13));
    chk("t2_writes", n_wr - w0, 2);

    w0 = n_wr;
    start(1'b0, 7, 7);
    send(4, 'h20, 1'b0);
    bus.s_tdata = 'h24;
    bus.s_tvalid = 1'b1;
    chk("t3_write_ready", bus.s_tready, 0);
    chk("t3_write_we", bus.bram_we, 1);
    chk("t3_write_addr", bus.bram_addr, 7);
    tick();
    chk("t3_done", done, 1);
    chk("t3_trunc", trunc, 1);
    chk("t3_done_ready", bus.s_tready, 0);
    tick();
    chk("t3_idle_ready", bus.s_tready, 0);
    chk("t3_trunc_sticky", trunc, 1);
    tick();
    chk("t3_idle_ready2", bus.s_tready, 0);
    bus.s_tvalid = 1'b0;
    chk("t3_addr7", mem[7], ln('h20, 'h21, 'h22, 'h23));
    chk("t3_writes", n_wr - w0, 1);

    preload(0);
    preload(1);
    w0 = n_wr;
    start(1'b1, 14, 1);
    chk("t4_trunc_clr", trunc, 0);
    chk("t4_fetch_en", bus.bram_en, 1);
    chk("t4_fetch_we", bus.bram_we, 0);
    read_run(14, 4, 16'hFFFF, 1'b0);
    chk("t4_writes", n_wr - w0, 0);

    w0 = n_wr;
    start(1'b1, 4, 5);
    read_run(4, 2, 16'b0110_1011_1001_1101, 1'b1);
    chk("t5_writes", n_wr - w0, 0);

    w0 = n_wr;
    start(1'b0, 9, 10);
    send(2, 'h30, 1'b0);
    bus.s_tdata = 'h32;
    bus.s_tvalid = 1'b1;
    rstn = 1'b0;
    #1;
    chk("t6_s_tready", bus.s_tready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_bram_en", bus.bram_en, 0);
    chk("t6_bram_addr", bus.bram_addr, 0);
    chk("t6_bram_din", bus.bram_din, 0);
    chk("t6_m_tvalid", bus.m_tvalid, 0);
    tick();
    tick();
    chk("t6_no_write", n_wr - w0, 0);
    bus.s_tvalid = 1'b0;
    rstn = 1'b1;
    tick();
    start(1'b0, 9, 9);
    send(4, 'h40, 1'b0);
    wait_done("t6_done");
    chk("t6_trunc", trunc, 1);
    tick();
    chk("t6_addr9", mem[9], ln('h40, 'h41, 'h42, 'h43));
    chk("t6_writes", n_wr - w0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
